// File: rtl/uart8_tx_streamer.sv
// uart8_tx_streamer: buffers bytes from a ready/valid producer and hands them one
// frame at a time to a Uart8 transmitter running on its own, slower clock. Every
// handshake with the transmitter is a level, so the clock ratio does not matter.
module uart8_tx_streamer #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          wrData,
    input  logic                          wrValid,
    output logic                          wrReady,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          txEn,
    output logic                          txStart,
    output logic [DATA_BITS-1:0]          txData,
    input  logic                          txBusy,
    output logic                          sent,
    output logic                          err,
    output logic                          idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } TxState;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [LVL_W-1:0]     wrPtr;
    logic [LVL_W-1:0]     rdPtr;
    logic                 push;
    logic                 pop;

    TxState               state;
    TxState               stateNext;
    logic [TMR_W-1:0]     timer;
    logic [TMR_W-1:0]     timerNext;
    logic [DATA_BITS-1:0] txDataNext;
    logic                 sentNext;
    logic                 errNext;

    // Pointers carry one extra wrap bit, so their difference is the occupancy directly.
    assign level   = wrPtr - rdPtr;
    assign wrReady = (level < LVL_W'(FIFO_DEPTH)) & ~rst;
    assign push    = wrValid & wrReady;
    assign idle    = (state == IDLE) && (level == '0);

    // Storage array; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[PTR_W-1:0]] <= wrData;
        end
    end

    // Write and read pointers; a push and a pop in the same cycle both advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + LVL_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + LVL_W'(1);
            end
        end
    end

    // Frame sequencing: load a byte, hold txStart until the transmitter reports busy
    // (or give up after the timeout), then wait for busy to drop before the next byte.
    always_comb begin
        stateNext  = state;
        timerNext  = timer;
        txDataNext = txData;
        pop        = 1'b0;
        sentNext   = 1'b0;
        errNext    = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    txDataNext = mem[rdPtr[PTR_W-1:0]];
                    pop        = 1'b1;
                    timerNext  = '0;
                    stateNext  = START;
                end
            end
            START: begin
                if (txBusy) begin
                    stateNext = WAIT;
                end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
                    errNext   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    timerNext = timer + TMR_W'(1);
                end
            end
            WAIT: begin
                if (!txBusy) begin
                    sentNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and registered outputs; txStart is registered so it is high exactly in START.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            txData  <= '0;
            txStart <= 1'b0;
            txEn    <= 1'b0;
            sent    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= stateNext;
            timer   <= timerNext;
            txData  <= txDataNext;
            txStart <= (stateNext == START);
            txEn    <= 1'b1;
            sent    <= sentNext;
            err     <= errNext;
        end
    end

endmodule
